// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage handshake between the pipeline and the M-extension sequencer
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, funct3, rs1_val, rs2_val, flush, input stall, busy, done, result);
  modport slave(input start, funct3, rs1_val, rs2_val, flush, output stall, busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M shift-add multiply / restoring divide with pipeline stall
module muldiv_sequencer #(parameter int XLEN = 32) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(XLEN);
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              is_div, sa, sb, div0, ovf, fast, accept;
  logic [XLEN-1:0]   mag_a, mag_b, word, res_calc;
  logic [XLEN:0]     msum;
  logic [XLEN+1:0]   dtry;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  assign is_div   = bus.funct3[2];
  assign sa       = (is_div ? ~bus.funct3[0] : bus.funct3[1] ^ bus.funct3[0]) & bus.rs1_val[XLEN-1];
  assign sb       = (is_div ? ~bus.funct3[0] : bus.funct3[1:0] == 2'b01) & bus.rs2_val[XLEN-1];
  assign mag_a    = sa ? -bus.rs1_val : bus.rs1_val;
  assign mag_b    = sb ? -bus.rs2_val : bus.rs2_val;
  assign div0     = is_div & (bus.rs2_val == '0);
  assign ovf      = is_div & ~bus.funct3[0] & (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.rs2_val);
  assign fast     = div0 | ovf;
  assign accept   = (state_q == IDLE) & bus.start & ~bus.flush;
  assign msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? opb_q : {XLEN{1'b0}}};
  assign mul_next = {msum, acc_q[XLEN-1:1]};
  assign dtry     = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b0, opb_q};
  assign div_next = dtry[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0} : {dtry[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign word     = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign res_calc = f3_q[2] ? (neg_q ? -word : word) : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign bus.busy   = state_q != IDLE;
  assign bus.stall  = ~rst & (accept | (state_q == EXEC));
  assign bus.done   = (state_q == DONE) & ~bus.flush;
  assign bus.result = bus.done ? res_calc : result_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (accept) begin
      f3_d    = bus.funct3;
      opb_d   = mag_b;
      neg_d   = ~fast & ((bus.funct3[2] & bus.funct3[1]) ? sa : sa ^ sb);
      cnt_d   = '0;
      acc_d   = div0 ? {bus.rs1_val, {XLEN{1'b1}}} : ovf ? {{XLEN{1'b0}}, bus.rs1_val} : {{XLEN{1'b0}}, mag_a};
      state_d = fast ? DONE : EXEC;
    end else if (state_q == EXEC) begin
      acc_d   = f3_q[2] ? div_next : mul_next;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(XLEN-1)) ? DONE : EXEC;
    end else if (state_q == DONE) begin
      result_d = res_calc;
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  muldiv_if bus();
  muldiv_sequencer dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat, input int poke);
    int n;
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    #1;
    chk({tag, "_stall0"}, bus.stall, 1);
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      chk({tag, "_stall"}, bus.stall, 1);
      if (n == poke) begin
        bus.start = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs2_val = 32'h0;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_result"}, bus.result, exp);
    chk({tag, "_stall_done"}, bus.stall, 0);
    tick();
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_result_hold"}, bus.result, exp);
  endtask
  initial begin
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.rs1_val = 32'd1;
    bus.rs2_val = 32'd1;
    bus.flush = 1'b0;
    tick();
    tick();
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 32'h0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, -1);
    op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, -1);
    op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, -1);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, -1);
    op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, -1);
    op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, -1);
    op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, -1);
    op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33, -1);
    op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, -1);
    op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1, -1);
    op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, -1);
    op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, -1);
    op("remu2", 3'b111, 32'd100, 32'd7, 32'd2, 33, -1);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct3 = 3'b000;
    #1;
    chk("flush_start_stall", bus.stall, 0);
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush_start_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.funct3 = 3'b100;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      chk("flush_busy_pre", bus.busy, 1);
      tick();
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_no_done", bus.done, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", bus.busy, 0);
    chk("flush_stall", bus.stall, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_result", bus.result, 32'd2);
    tick();
    op("mul_after_flush", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, -1);
    op("mulhu_poke", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 5);
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.rs1_val = 32'd100;
    bus.rs2_val = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_result", bus.result, 32'h0);
    op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33, -1);
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd0;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("flush_done_cycle_done", bus.done, 0);
    chk("flush_done_cycle_result", bus.result, 32'd14);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_done_cycle_busy", bus.busy, 0);
    chk("flush_done_cycle_hold", bus.result, 32'd14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
